// File: rtl/alu_multi_if.sv
// rtl/alu_multi_if.sv - start/busy/done handshake and operand/result bus for alu_multi
interface alu_multi_if #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 4
);
  localparam int TOT = WIDTH * DIGITS;

  logic           start;
  logic [2:0]     op;
  logic [TOT-1:0] a;
  logic [TOT-1:0] b;
  logic           cin;
  logic           busy;
  logic           done;
  logic [TOT-1:0] result;
  logic           cout;
  logic           zero;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, result, cout, zero
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, result, cout, zero
  );
endinterface

// File: rtl/alu_multi.sv
// rtl/alu_multi.sv - digit-serial multi-digit ALU; optional zero flag enabled by ALU_MULTI_ZERO_FLAG_EN
module alu_multi #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 4
) (
  input logic        clock,
  input logic        reset_n,
  alu_multi_if.slave bus
);
  localparam int TOT   = WIDTH * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_BCD = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;
  localparam logic [2:0] OP_LG2 = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [TOT-1:0]   a_sh;
  logic [TOT-1:0]   b_sh;
  logic [TOT-1:0]   acc;
  logic [2:0]       op_r;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             busy_r;
  logic             done_r;
  logic             cout_r;
  logic [TOT-1:0]   result_r;

  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] dig;
  logic             dig_c;
  logic [TOT-1:0]   acc_next;
  logic [TOT-1:0]   lg2;
  logic [TOT-1:0]   single_res;
  logic             single_c;
  logic             is_serial;
  logic             complete;
  logic [TOT-1:0]   fin_res;
  logic             fin_c;

  // Digit slice: low digit of the shifting operands plus running carry, with decimal adjust
  always_comb begin
    a_d   = a_sh[WIDTH-1:0];
    b_d   = (op_r == OP_SUB) ? ~b_sh[WIDTH-1:0] : b_sh[WIDTH-1:0];
    sum   = {1'b0, a_d} + {1'b0, b_d} + {{WIDTH{1'b0}}, carry};
    dig   = sum[WIDTH-1:0];
    dig_c = sum[WIDTH];
    // Decimal correction only makes sense for 4-bit digits; other widths fall back to binary add
    if (WIDTH == 4 && op_r == OP_BCD && sum > (WIDTH+1)'(9)) begin
      dig   = sum[WIDTH-1:0] + WIDTH'(6);
      dig_c = 1'b1;
    end
    // Result digits enter at the top so the final word is aligned after DIGITS shifts
    acc_next = (acc >> WIDTH) | (TOT'(dig) << (TOT - WIDTH));
  end

  // Word-level log2+1: zero stays zero, one-hot gives bit position+1, anything else saturates
  always_comb begin
    lg2 = '0;
    if (a_sh != '0) begin
      if ((a_sh & (a_sh - TOT'(1))) != '0) begin
        lg2 = '1;
      end else begin
        for (int i = 0; i < TOT; i++) begin
          if (a_sh[i]) lg2 = TOT'(i + 1);
        end
      end
    end
  end

  // Single-cycle ops and completion selection
  always_comb begin
    single_res = a_sh;
    single_c   = carry;
    is_serial  = 1'b0;
    case (op_r)
      OP_ADD, OP_SUB, OP_BCD: is_serial = 1'b1;
      OP_ROL: {single_c, single_res} = {a_sh, carry};
      OP_ROR: {single_res, single_c} = {carry, a_sh};
      OP_LG2: begin
        single_res = lg2;
        single_c   = 1'b0;
      end
      default: ;
    endcase
    complete = !is_serial || (idx == LAST);
    fin_res  = is_serial ? acc_next : single_res;
    fin_c    = is_serial ? dig_c : single_c;
  end

`ifdef ALU_MULTI_ZERO_FLAG_EN
  logic zero_r;
  assign bus.zero = zero_r;
`else
  assign bus.zero = 1'b0;
`endif

  // Control FSM: accept in IDLE, step digits in RUN, publish result and pulse done on exit
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      cout_r   <= 1'b0;
      idx      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      op_r     <= OP_ADD;
      carry    <= 1'b0;
`ifdef ALU_MULTI_ZERO_FLAG_EN
      zero_r   <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            op_r   <= bus.op;
            carry  <= bus.cin;
            idx    <= '0;
            acc    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (is_serial) begin
            a_sh  <= a_sh >> WIDTH;
            b_sh  <= b_sh >> WIDTH;
            carry <= dig_c;
            acc   <= acc_next;
            idx   <= idx + IDX_W'(1);
          end
          if (complete) begin
            result_r <= fin_res;
            cout_r   <= fin_c;
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state    <= IDLE;
`ifdef ALU_MULTI_ZERO_FLAG_EN
            zero_r   <= (fin_res == '0);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.cout   = cout_r;
endmodule

// File: tb/tb_alu_multi.sv
// tb/tb_alu_multi.sv - self-checking bench for alu_multi (WIDTH=4, DIGITS=4)
module tb_alu_multi;
  localparam int W = 4;
  localparam int D = 4;

`ifdef ALU_MULTI_ZERO_FLAG_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  alu_multi_if #(.WIDTH(W), .DIGITS(D)) bus();
  alu_multi #(.WIDTH(W), .DIGITS(D)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    int m = 1;
    for (int i = 0; i < 4; i++) begin
      r += int'(v[4*i +: 4]) * m;
      m *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Reference: {cout, result} from the arithmetic meaning of each op
  function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    logic [15:0] r;
    logic c;
    int unsigned s;
    int v;
    case (op)
      3'd0: begin
        s = 32'(a) + 32'(b) + 32'(cin);
        r = s[15:0];
        c = s[16];
      end
      3'd1: begin
        r = a - b - 16'(!cin);
        c = (int'(a) >= int'(b) + int'(!cin));
      end
      3'd2: begin
        v = bcd2int(a) + bcd2int(b) + int'(cin);
        r = int2bcd(v % 10000);
        c = (v >= 10000);
      end
      3'd3: {c, r} = {a, cin};
      3'd4: {r, c} = {cin, a};
      3'd5: begin
        c = 1'b0;
        if (a == 0) r = 0;
        else if ($countones(a) != 1) r = 16'hFFFF;
        else begin
          r = 0;
          for (int k = 0; k < 16; k++) if (a[k]) r = 16'(k + 1);
        end
      end
      default: begin
        r = a;
        c = cin;
      end
    endcase
    return {c, r};
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin,
                       output int lat, output logic busy_acc, output logic [15:0] res,
                       output logic c, output logic z, output logic done_after);
    @(negedge clock);
    bus.op = op; bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    busy_acc = bus.busy;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 64) begin
      @(negedge clock);
      lat++;
    end
    res = bus.result; c = bus.cout; z = bus.zero;
    @(negedge clock);
    done_after = bus.done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", bus.done); end
    tests++; if (bus.result !== 16'h0) begin fails++; $display("FAIL reset_result got=%h want=0000", bus.result); end
    tests++; if (bus.cout !== 1'b0) begin fails++; $display("FAIL reset_cout got=%b want=0", bus.cout); end
    tests++; if (bus.zero !== 1'b0) begin fails++; $display("FAIL reset_zero got=%b want=0", bus.zero); end
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic        c;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[12];
    int lat;
    logic ba, c, z, da;
    logic [15:0] r;
    v[0]  = '{3'd0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 4};
    v[1]  = '{3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4};
    v[2]  = '{3'd1, 16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1, 4};
    v[3]  = '{3'd1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 4};
    v[4]  = '{3'd2, 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 4};
    v[5]  = '{3'd2, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 4};
    v[6]  = '{3'd3, 16'h8001, 16'h0000, 1'b0, 16'h0002, 1'b1, 1};
    v[7]  = '{3'd4, 16'h0001, 16'h0000, 1'b1, 16'h8000, 1'b1, 1};
    v[8]  = '{3'd5, 16'h0100, 16'h0000, 1'b0, 16'h0009, 1'b0, 1};
    v[9]  = '{3'd5, 16'h0101, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1};
    v[10] = '{3'd5, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1};
    v[11] = '{3'd6, 16'hABCD, 16'h1111, 1'b1, 16'hABCD, 1'b1, 1};
    for (int i = 0; i < 12; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].cin, lat, ba, r, c, z, da);
      tests++; if (lat !== v[i].lat) begin fails++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, v[i].lat); end
      tests++; if (r !== v[i].res) begin fails++; $display("FAIL dir%0d_result got=%h want=%h", i, r, v[i].res); end
      tests++; if (c !== v[i].c) begin fails++; $display("FAIL dir%0d_cout got=%b want=%b", i, c, v[i].c); end
      tests++; if (z !== (ZF && v[i].res == 16'h0)) begin fails++; $display("FAIL dir%0d_zero got=%b want=%b", i, z, ZF && v[i].res == 16'h0); end
      tests++; if (ba !== 1'b1) begin fails++; $display("FAIL dir%0d_busy got=%b want=1", i, ba); end
      tests++; if (da !== 1'b0) begin fails++; $display("FAIL dir%0d_done_width got=%b want=0", i, da); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic ba, c, z, da;
    logic [15:0] r, a, b;
    logic [2:0] op;
    logic cin;
    logic [16:0] e;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      if (op == 3'd2) begin a = rand_bcd(); b = rand_bcd(); end
      if (op == 3'd5 && $urandom_range(0, 1) == 1) a = 16'h1 << $urandom_range(0, 15);
      e = model(op, a, b, cin);
      do_op(op, a, b, cin, lat, ba, r, c, z, da);
      tests++; if (lat !== ((op <= 3'd2) ? 4 : 1)) begin fails++; $display("FAIL rnd%0d_latency op=%0d got=%0d", i, op, lat); end
      tests++; if (r !== e[15:0]) begin fails++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h cin=%b got=%h want=%h", i, op, a, b, cin, r, e[15:0]); end
      tests++; if (c !== e[16]) begin fails++; $display("FAIL rnd%0d_cout op=%0d got=%b want=%b", i, op, c, e[16]); end
      tests++; if (z !== (ZF && e[15:0] == 16'h0)) begin fails++; $display("FAIL rnd%0d_zero got=%b", i, z); end
      tests++; if (da !== 1'b0) begin fails++; $display("FAIL rnd%0d_done_width got=%b want=0", i, da); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clock);
    bus.op = 3'd0; bus.a = 16'h1234; bus.b = 16'h0FFF; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    bus.op = 3'd3; bus.a = 16'h8001; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    lat = 2;
    while (bus.done !== 1'b1 && lat < 64) begin
      @(negedge clock);
      lat++;
    end
    tests++; if (lat !== 4) begin fails++; $display("FAIL b2b_ignore_latency got=%0d want=4", lat); end
    tests++; if (bus.result !== 16'h2233) begin fails++; $display("FAIL b2b_ignore_result got=%h want=2233", bus.result); end
    bus.op = 3'd1; bus.a = 16'h1000; bus.b = 16'h0001; bus.cin = 1'b1; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_accept_on_done got=%b want=1", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL b2b_done_width got=%b want=0", bus.done); end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 64) begin
      @(negedge clock);
      lat++;
    end
    tests++; if (lat !== 4) begin fails++; $display("FAIL b2b_second_latency got=%0d want=4", lat); end
    tests++; if (bus.result !== 16'h0FFF || bus.cout !== 1'b1) begin
      fails++; $display("FAIL b2b_second_result got=%h/%b want=0fff/1", bus.result, bus.cout);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    int lat;
    logic ba, c, z, da;
    logic [15:0] r;
    @(negedge clock);
    bus.op = 3'd0; bus.a = 16'h1234; bus.b = 16'h0FFF; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    bus.op = 3'd3; bus.a = 16'h8001; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    tests++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      fails++; $display("FAIL abort_midrun busy/done got=%b/%b want=1/0", bus.busy, bus.done);
    end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL abort_done got=%b want=0", bus.done); end
    tests++; if (bus.result !== 16'h0) begin fails++; $display("FAIL abort_result got=%h want=0000", bus.result); end
    tests++; if (bus.cout !== 1'b0) begin fails++; $display("FAIL abort_cout got=%b want=0", bus.cout); end
    pulses = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.done === 1'b1) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL abort_no_done got=%0d want=0", pulses); end
    do_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, lat, ba, r, c, z, da);
    tests++; if (lat !== 4 || r !== 16'h0000 || c !== 1'b1) begin
      fails++; $display("FAIL abort_restart got=lat%0d %h/%b want=lat4 0000/1", lat, r, c);
    end
    tests++; if (z !== ZF) begin fails++; $display("FAIL abort_restart_zero got=%b want=%b", z, ZF); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
